// File: rtl/fetch_queue_if.sv
// ----------------------------------------------------------------------------
// fetch_queue_if
// Groups the fetch front end's bus signals into one bundle:
//   imem_en / imem_addr / imem_rdata    : synchronous-read instruction memory
//   redirect_valid / redirect_pc        : branch/jump redirect from downstream
//   out_valid / out_ready / out_instr /
//   out_pc / fill                       : decoder handshake and queue level
// Modport master is the fetch queue side; modport slave is the environment
// (memory, redirect source, decoder).
// ----------------------------------------------------------------------------
interface fetch_queue_if #(
    parameter int AW = 32,
    parameter int CW = 3
);
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_pc;
    logic [CW-1:0] fill;

    modport master (
        output imem_en,
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output fill
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  fill
    );
endinterface

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
// Instruction-fetch front end. Owns the fetch PC, issues word reads to a
// synchronous-read instruction memory, buffers each returned instruction
// together with its PC in a QDEPTH-entry circular queue and presents the head
// to decode over a valid/ready handshake. A redirect flushes the queue, drops
// the in-flight read and restarts fetch at the (word-aligned) target.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - fetch_queue_if.master (memory, redirect and decoder signals)
// ----------------------------------------------------------------------------
module fetch_queue #(
    parameter int          AW       = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          QDEPTH   = 4,
    parameter int          CW       = $clog2(QDEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    fetch_queue_if.master bus
);
    localparam int            PW       = $clog2(QDEPTH);
    localparam logic [AW-1:0] PC_STEP  = AW'(4);
    localparam logic [AW-1:0] PC_RESET = AW'(RESET_PC);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] FILL_ONE = CW'(1);
    localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(QDEPTH);

    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] pend_pc_q, pend_pc_d;
    logic          inflight_q, inflight_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] fill_q, fill_d;
    logic [31:0]   instr_mem_q [QDEPTH];
    logic [AW-1:0] pc_mem_q    [QDEPTH];

    logic          issue_s;
    logic          push_s;
    logic          pop_s;
    logic [CW:0]   occupancy_s;
    logic [1:0]    unused_redirect_lsb_s;

    assign unused_redirect_lsb_s = bus.redirect_pc[1:0];

    // Occupancy counts the outstanding read so a returning word always has a slot.
    assign occupancy_s = {1'b0, fill_q} + {{CW{1'b0}}, inflight_q};
    assign issue_s     = !rst && !bus.redirect_valid && (occupancy_s < DEPTH_W);
    // Redirect wins over both push and pop in the same cycle.
    assign push_s      = inflight_q && !bus.redirect_valid;
    assign pop_s       = (fill_q != '0) && bus.out_ready && !bus.redirect_valid;

    // Next-state logic for PC, in-flight tracking, pointers and fill level.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        inflight_d = inflight_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fill_d     = fill_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = {bus.redirect_pc[AW-1:2], 2'b00};
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fill_d     = '0;
        end else begin
            inflight_d = issue_s;
            if (issue_s) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
                pend_pc_d  = fetch_pc_q;
            end else begin
                fetch_pc_d = fetch_pc_q;
                pend_pc_d  = pend_pc_q;
            end
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   fill_d = fill_q + FILL_ONE;
                2'b01:   fill_d = fill_q - FILL_ONE;
                default: fill_d = fill_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= PC_RESET;
            pend_pc_q  <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
        end
    end

    // Queue storage; cleared on reset so the head reads as zero until first push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                instr_mem_q[i] <= 32'h0000_0000;
                pc_mem_q[i]    <= '0;
            end
        end else if (push_s) begin
            instr_mem_q[wr_ptr_q] <= bus.imem_rdata;
            pc_mem_q[wr_ptr_q]    <= pend_pc_q;
        end else begin
            instr_mem_q[wr_ptr_q] <= instr_mem_q[wr_ptr_q];
            pc_mem_q[wr_ptr_q]    <= pc_mem_q[wr_ptr_q];
        end
    end

    assign bus.imem_en   = issue_s;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.out_valid = (fill_q != '0);
    assign bus.out_instr = instr_mem_q[rd_ptr_q];
    assign bus.out_pc    = pc_mem_q[rd_ptr_q];
    assign bus.fill      = fill_q;
endmodule
